// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - shared encodings for the serial two's-complement engine
package tc_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_NEG  = 2'b01;
    localparam logic [1:0] MODE_ABS  = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic logic mode_is_neg(input logic [1:0] m);
        return m == MODE_NEG;
    endfunction

    // Code 11 falls through to pass because it is neither NEG nor ABS.
    function automatic logic mode_is_abs(input logic [1:0] m);
        return m == MODE_ABS;
    endfunction

endpackage

// File: rtl/serial_neg_lane.sv
// rtl/serial_neg_lane.sv - one serial lane: negate rule, abs capture buffer, ovf flag
module serial_neg_lane
    import tc_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          r,
    input  logic          load,
    input  logic          emit,
    input  logic          shift,
    input  logic          drain,
    input  logic          neg_mode,
    input  logic          last,
    input  logic [CW-1:0] idx,
    input  logic          bit_in,
    output logic          y,
    output logic          ovf
);

    logic [W-1:0] abs_buf;
    logic         seen_one;
    logic         src;
    logic         seen_eff;
    logic         do_neg;

    // During drain the captured word's MSB decides whether this lane negates.
    always_comb begin
        src      = drain ? abs_buf[idx] : bit_in;
        seen_eff = load ? 1'b0 : seen_one;
        do_neg   = drain ? abs_buf[W-1] : neg_mode;
    end

    always_ff @(posedge clk) begin
        if (r) begin
            y        <= 1'b0;
            ovf      <= 1'b0;
            seen_one <= 1'b0;
            abs_buf  <= '0;
        end else begin
            y <= emit & (src ^ (do_neg & seen_eff));
            if (emit)
                seen_one <= seen_eff | src;
            else if (load)
                seen_one <= 1'b0;
            if (shift)
                abs_buf <= {bit_in, abs_buf[W-1:1]};
            // Only the most negative value has MSB=1 with no earlier one.
            if (load)
                ovf <= 1'b0;
            else if (emit && last)
                ovf <= do_neg & src & ~seen_eff;
        end
    end

endmodule

// File: rtl/serial_twos_comp_n.sv
// rtl/serial_twos_comp_n.sv - multi-lane bit-serial pass/negate/abs engine with shared frame control
module serial_twos_comp_n
    import tc_pkg::*;
#(
    parameter int W  = 8,
    parameter int CH = 2
) (
    input  logic          t_clk,
    input  logic          r,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [CH-1:0] i,
    output logic [CH-1:0] y,
    output logic          valid,
    output logic          done,
    output logic          busy,
    output logic [CH-1:0] ovf
);

    localparam int            CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] count;
    logic [CW-1:0] count_n;
    logic [1:0]    mode_q;
    logic [1:0]    mode_eff;
    logic          load;
    logic          emit;
    logic          shift;
    logic          drain;
    logic          last;
    logic          neg_mode;

    always_comb begin
        state_n  = state;
        count_n  = count;
        mode_eff = mode_q;
        load     = 1'b0;
        emit     = 1'b0;
        shift    = 1'b0;
        drain    = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    mode_eff = mode;
                    emit     = !mode_is_abs(mode);
                    shift    = mode_is_abs(mode);
                    state_n  = RUN;
                    count_n  = CW'(1);
                end
            end
            RUN: begin
                emit  = !mode_is_abs(mode_q);
                shift = mode_is_abs(mode_q);
                last  = (count == LAST_IDX);
                if (last) begin
                    state_n = mode_is_abs(mode_q) ? DRAIN : IDLE;
                    count_n = '0;
                end else begin
                    count_n = count + CW'(1);
                end
            end
            DRAIN: begin
                emit  = 1'b1;
                drain = 1'b1;
                last  = (count == LAST_IDX);
                if (last) begin
                    state_n = IDLE;
                    count_n = '0;
                end else begin
                    count_n = count + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        neg_mode = mode_is_neg(mode_eff);
    end

    always_ff @(posedge t_clk) begin
        if (r) begin
            state  <= IDLE;
            count  <= '0;
            mode_q <= MODE_PASS;
            valid  <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            if (load)
                mode_q <= mode;
            valid <= emit;
            done  <= emit & last;
        end
    end

    assign busy = (state != IDLE);

    for (genvar g = 0; g < CH; g++) begin : g_lane
        serial_neg_lane #(.W(W), .CW(CW)) u_lane (
            .clk     (t_clk),
            .r       (r),
            .load    (load),
            .emit    (emit),
            .shift   (shift),
            .drain   (drain),
            .neg_mode(neg_mode),
            .last    (last),
            .idx     (count),
            .bit_in  (i[g]),
            .y       (y[g]),
            .ovf     (ovf[g])
        );
    end

endmodule

// File: tb/tb_serial_twos_comp_n.sv
// tb/tb_serial_twos_comp_n.sv - randomized and directed bench against a word-level reference model
module tb_serial_twos_comp_n;
    import tc_pkg::*;

    localparam int W    = 8;
    localparam int CH   = 2;
    localparam int MAXC = 8192;

    logic          t_clk = 1'b0;
    logic          r;
    logic          start;
    logic [1:0]    mode;
    logic [CH-1:0] i;
    logic [CH-1:0] y;
    logic          valid;
    logic          done;
    logic          busy;
    logic [CH-1:0] ovf;

    serial_twos_comp_n #(.W(W), .CH(CH)) dut (
        .t_clk(t_clk),
        .r    (r),
        .start(start),
        .mode (mode),
        .i    (i),
        .y    (y),
        .valid(valid),
        .done (done),
        .busy (busy),
        .ovf  (ovf)
    );

    always #5 t_clk = ~t_clk;

    int cyc = 0;
    always @(posedge t_clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Per-cycle expectations, filled in ahead of time whenever a frame is accepted.
    logic          ev    [MAXC];
    logic          ed    [MAXC];
    logic          eb    [MAXC];
    logic          eychk [MAXC];
    logic [CH-1:0] ey    [MAXC];
    logic [CH-1:0] eovf  [MAXC];

    int         free_at   = 0;
    int         cap_start = -100;
    logic [W-1:0] cap_w  [CH];
    logic [W-1:0] next_w [CH];

    logic [W-1:0] acc       [CH];
    logic [W-1:0] last_word [CH];
    logic [W-1:0] prev_word [CH];
    int   last_done_cyc   = -1;
    int   first_valid_cyc = -1;
    int   frame_first     = -1;
    logic prev_valid = 1'b0;
    logic prev_done  = 1'b0;

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    function automatic void ref_word(input logic [W-1:0] w, input logic [1:0] m,
                                     output logic [W-1:0] res, output logic of);
        logic [W-1:0] minw;
        minw = '0;
        minw[W-1] = 1'b1;
        res = w;
        of  = 1'b0;
        if (m == MODE_NEG || (m == MODE_ABS && w[W-1])) begin
            res = ~w + 1'b1;
            of  = (w == minw);
        end
    endfunction

    task automatic model_reset(input int c);
        for (int t = c + 1; t < MAXC; t++) begin
            ev[t] = 1'b0; ed[t] = 1'b0; eb[t] = 1'b0;
            ey[t] = '0; eovf[t] = '0; eychk[t] = 1'b0;
        end
        if (c + 1 < MAXC) eychk[c+1] = 1'b1;
        free_at   = c + 1;
        cap_start = -100;
    endtask

    task automatic model_accept(input int c, input logic [1:0] m);
        logic [W-1:0]  res [CH];
        logic [CH-1:0] of;
        logic [W-1:0]  rw;
        logic          ro;
        int L;
        int off;
        for (int ch = 0; ch < CH; ch++) begin
            ref_word(next_w[ch], m, rw, ro);
            res[ch] = rw;
            of[ch]  = ro;
        end
        L   = (m == MODE_ABS) ? 2 * W : W;
        off = (m == MODE_ABS) ? W : 0;
        for (int t = c + 1; t < MAXC; t++) eovf[t] = '0;
        for (int k = 0; k < W; k++) begin
            int t;
            t = c + 1 + off + k;
            if (t < MAXC) begin
                ev[t]    = 1'b1;
                ed[t]    = (k == W - 1);
                eychk[t] = 1'b1;
                for (int ch = 0; ch < CH; ch++) ey[t][ch] = res[ch][k];
            end
        end
        for (int t = c + 1; t < c + L && t < MAXC; t++) eb[t] = 1'b1;
        for (int t = c + L; t < MAXC; t++) eovf[t] = of;
        free_at   = c + L;
        cap_start = c;
        for (int ch = 0; ch < CH; ch++) cap_w[ch] = next_w[ch];
    endtask

    // Drive one cycle of inputs (called at a falling edge) and advance to the next falling edge.
    task automatic step(input logic st, input logic [1:0] md, input logic rr);
        int c;
        c = cyc;
        r = rr;
        start = st;
        mode = md;
        if (rr)
            model_reset(c);
        else if (st && c >= free_at)
            model_accept(c, md);
        for (int ch = 0; ch < CH; ch++) begin
            if (cap_start >= 0 && c >= cap_start && c - cap_start < W)
                i[ch] = cap_w[ch][c - cap_start];
            else
                i[ch] = 1'($urandom_range(0, 1));
        end
        @(negedge t_clk);
    endtask

    task automatic frame(input logic [1:0] md, input logic [W-1:0] w0, input logic [W-1:0] w1, output int c0);
        int L;
        L = (md == MODE_ABS) ? 2 * W : W;
        next_w[0] = w0;
        next_w[1] = w1;
        c0 = cyc;
        step(1'b1, md, 1'b0);
        repeat (L) step(1'b0, md, 1'b0);
        #1;
    endtask

    always @(negedge t_clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            check("valid", cyc, 32'(valid), 32'(ev[cyc]));
            check("done",  cyc, 32'(done),  32'(ed[cyc]));
            check("busy",  cyc, 32'(busy),  32'(eb[cyc]));
            check("ovf",   cyc, 32'(ovf),   32'(eovf[cyc]));
            if (eychk[cyc]) check("y", cyc, 32'(y), 32'(ey[cyc]));
            if (valid === 1'b1) begin
                if (!prev_valid || prev_done) frame_first = cyc;
                for (int ch = 0; ch < CH; ch++) acc[ch] = {y[ch], acc[ch][W-1:1]};
                if (done === 1'b1) begin
                    for (int ch = 0; ch < CH; ch++) begin
                        prev_word[ch] = last_word[ch];
                        last_word[ch] = acc[ch];
                    end
                    last_done_cyc   = cyc;
                    first_valid_cyc = frame_first;
                end
            end
            prev_valid = valid;
            prev_done  = done;
        end
    end

    initial begin
        int c0;
        logic [W-1:0] pw;
        logic po;

        for (int t = 0; t < MAXC; t++) begin
            ev[t] = 1'b0; ed[t] = 1'b0; eb[t] = 1'b0;
            ey[t] = '0; eovf[t] = '0; eychk[t] = 1'b0;
        end
        for (int ch = 0; ch < CH; ch++) begin
            acc[ch] = '0; last_word[ch] = '0; prev_word[ch] = '0;
            cap_w[ch] = '0; next_w[ch] = '0;
        end
        r = 1'b1;
        start = 1'b0;
        mode = 2'b00;
        i = '0;
        model_reset(0);

        ref_word(8'h06, MODE_NEG, pw, po);
        check("model_neg06", 0, 32'(pw), 32'h0FA);
        ref_word(8'h80, MODE_NEG, pw, po);
        check("model_neg80", 0, 32'({po, pw}), 32'h180);
        ref_word(8'hFB, MODE_ABS, pw, po);
        check("model_absFB", 0, 32'({po, pw}), 32'h005);
        ref_word(8'hA5, 2'b11, pw, po);
        check("model_m11", 0, 32'({po, pw}), 32'h0A5);

        @(negedge t_clk);
        step(1'b1, MODE_NEG, 1'b1);
        step(1'b0, MODE_PASS, 1'b1);
        step(1'b0, MODE_PASS, 1'b0);

        frame(MODE_NEG, 8'h06, 8'h00, c0);
        check("neg06_l0", cyc, 32'(last_word[0]), 32'h0FA);
        check("neg06_l1", cyc, 32'(last_word[1]), 32'h000);
        check("neg06_done_cyc", cyc, 32'(last_done_cyc - c0), 32'd8);
        check("neg06_first_cyc", cyc, 32'(first_valid_cyc - c0), 32'd1);
        check("neg06_ovf", cyc, 32'(ovf), 32'h0);

        frame(MODE_NEG, 8'h80, 8'h01, c0);
        check("neg80_l0", cyc, 32'(last_word[0]), 32'h080);
        check("neg01_l1", cyc, 32'(last_word[1]), 32'h0FF);
        check("neg80_ovf", cyc, 32'(ovf), 32'h1);
        repeat (3) step(1'b0, MODE_PASS, 1'b0);
        #1;
        check("neg80_ovf_held", cyc, 32'(ovf), 32'h1);

        frame(MODE_ABS, 8'hFB, 8'h05, c0);
        check("absFB_l0", cyc, 32'(last_word[0]), 32'h005);
        check("abs05_l1", cyc, 32'(last_word[1]), 32'h005);
        check("abs_done_cyc", cyc, 32'(last_done_cyc - c0), 32'd16);
        check("abs_first_cyc", cyc, 32'(first_valid_cyc - c0), 32'd9);
        check("abs_ovf", cyc, 32'(ovf), 32'h0);

        frame(MODE_ABS, 8'h80, 8'h7F, c0);
        check("abs80_l0", cyc, 32'(last_word[0]), 32'h080);
        check("abs7F_l1", cyc, 32'(last_word[1]), 32'h07F);
        check("abs80_ovf", cyc, 32'(ovf), 32'h1);

        c0 = cyc;
        next_w[0] = 8'h01; next_w[1] = 8'h03;
        step(1'b1, MODE_NEG, 1'b0);
        repeat (W - 1) step(1'b0, MODE_NEG, 1'b0);
        next_w[0] = 8'h02; next_w[1] = 8'hFF;
        step(1'b1, MODE_NEG, 1'b0);
        repeat (W) step(1'b0, MODE_NEG, 1'b0);
        #1;
        check("b2b_first_l0", cyc, 32'(prev_word[0]), 32'h0FF);
        check("b2b_first_l1", cyc, 32'(prev_word[1]), 32'h0FD);
        check("b2b_second_l0", cyc, 32'(last_word[0]), 32'h0FE);
        check("b2b_second_l1", cyc, 32'(last_word[1]), 32'h001);
        check("b2b_done_cyc", cyc, 32'(last_done_cyc - c0), 32'd16);
        check("b2b_second_first", cyc, 32'(first_valid_cyc - c0), 32'd9);

        c0 = cyc;
        next_w[0] = 8'hFB; next_w[1] = 8'h05;
        step(1'b1, MODE_ABS, 1'b0);
        repeat (2) step(1'b0, MODE_ABS, 1'b0);
        next_w[0] = 8'h11; next_w[1] = 8'h22;
        step(1'b1, MODE_NEG, 1'b0);
        repeat (8) step(1'b0, MODE_ABS, 1'b0);
        step(1'b0, MODE_ABS, 1'b1);
        #1;
        check("rst_cyc", cyc, 32'(cyc - c0), 32'd13);
        check("rst_valid", cyc, 32'(valid), 32'h0);
        check("rst_busy", cyc, 32'(busy), 32'h0);
        check("rst_done", cyc, 32'(done), 32'h0);
        check("rst_y", cyc, 32'(y), 32'h0);
        frame(MODE_NEG, 8'h06, 8'h80, c0);
        check("post_rst_l0", cyc, 32'(last_word[0]), 32'h0FA);
        check("post_rst_l1", cyc, 32'(last_word[1]), 32'h080);
        check("post_rst_ovf", cyc, 32'(ovf), 32'h2);

        frame(MODE_PASS, 8'hA5, 8'h5A, c0);
        check("pass_l0", cyc, 32'(last_word[0]), 32'h0A5);
        check("pass_l1", cyc, 32'(last_word[1]), 32'h05A);
        check("pass_ovf", cyc, 32'(ovf), 32'h0);
        frame(2'b11, 8'hA5, 8'h80, c0);
        check("m11_l0", cyc, 32'(last_word[0]), 32'h0A5);
        check("m11_l1", cyc, 32'(last_word[1]), 32'h080);
        check("m11_ovf", cyc, 32'(ovf), 32'h0);

        for (int n = 0; n < 150 && cyc < MAXC - 64; n++) begin
            logic [1:0] m;
            m = 2'($urandom_range(0, 3));
            while (cyc < free_at) begin
                for (int ch = 0; ch < CH; ch++) next_w[ch] = W'($urandom);
                step($urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 79) == 0);
            end
            for (int ch = 0; ch < CH; ch++) begin
                case ($urandom_range(0, 5))
                    0:       next_w[ch] = 8'h80;
                    1:       next_w[ch] = 8'h00;
                    default: next_w[ch] = W'($urandom);
                endcase
            end
            step(1'b1, m, 1'b0);
            repeat ($urandom_range(0, 2)) step(1'b0, 2'($urandom_range(0, 3)), 1'b0);
        end
        repeat (2 * W + 2) step(1'b0, MODE_PASS, 1'b0);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
